// File: rtl/aud_pkg.sv
// Shared types and defaults for the audio sample-to-PWM back-end.
package aud_pkg;

    // Playback sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } aud_state_t;

    // Default geometry of the audio path.
    localparam int AUD_SAMPLE_W   = 8;
    localparam int AUD_FIFO_DEPTH = 16;
    localparam int AUD_PWM_REPEAT = 8;
    localparam int AUD_PRIME_LVL  = 4;

    // Midscale code for an unsigned sample of the given width: the silence level.
    function automatic logic [31:0] midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/aud_sample_fifo.sv
// Synchronous sample FIFO with occupancy, full and empty; synchronous active-low reset.
module aud_sample_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = ADDR_W + 1;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [ADDR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic               do_push;
    logic               do_pop;

    assign level_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (level_o == '0);
    assign full_o  = (level_o == LVL_W'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_ptr_q[ADDR_W-1:0]];

    // Next pointer values: advance only on an accepted push or pop.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage written on accepted pushes.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; the pointers alone decide which entries are valid.
        if (do_push) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_i;
    end

endmodule

// File: rtl/aud_sample_pwm.sv
// Audio back-end: buffers PCM samples, primes, paces one sample per
// PWM_REPEAT PWM periods and renders each as a PWM duty on aud_pwm_o.
module aud_sample_pwm
    import aud_pkg::*;
#(
    parameter int SAMPLE_W   = AUD_SAMPLE_W,
    parameter int FIFO_DEPTH = AUD_FIFO_DEPTH,
    parameter int PWM_REPEAT = AUD_PWM_REPEAT,
    parameter int PRIME_LVL  = AUD_PRIME_LVL
) (
    input  logic                           pclk_i,
    input  logic                           presetn_i,
    input  logic                           enable_i,
    input  logic [SAMPLE_W-1:0]            sample_i,
    input  logic                           sample_valid_i,
    output logic                           sample_ready_o,
    input  logic                           clr_underrun_i,
    output logic [$clog2(FIFO_DEPTH):0]    level_o,
    output logic                           empty_o,
    output logic                           full_o,
    output logic                           underrun_o,
    output logic                           busy_o,
    output logic                           aud_pwm_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int REP_W = (PWM_REPEAT > 1) ? $clog2(PWM_REPEAT) : 1;
    localparam logic [REP_W-1:0]    REP_LAST = REP_W'(PWM_REPEAT - 1);
    localparam logic [SAMPLE_W-1:0] SILENCE  = SAMPLE_W'(midscale(SAMPLE_W));

    aud_state_t             state_q;
    logic [SAMPLE_W-1:0]    cur_sample_q;
    logic [SAMPLE_W-1:0]    cnt_q, cnt_d;
    logic [REP_W-1:0]       rep_q, rep_d;
    logic                   underrun_q;
    logic                   pwm_q;

    logic [SAMPLE_W-1:0]    fifo_head;
    logic                   fifo_pop;
    logic                   primed;
    logic                   boundary;
    logic                   underrun_set;

    aud_sample_fifo #(
        .DATA_W (SAMPLE_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (pclk_i),
        .rst_ni  (presetn_i),
        .push_i  (sample_valid_i),
        .data_i  (sample_i),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .level_o (level_o),
        .empty_o (empty_o),
        .full_o  (full_o)
    );

    assign sample_ready_o = !full_o;
    assign underrun_o     = underrun_q;
    assign busy_o         = (state_q == PLAY);
    assign aud_pwm_o      = pwm_q;

    // Sample-boundary detection, pop requests and counter increments.
    always_comb begin
        primed       = (level_o >= LVL_W'(PRIME_LVL));
        boundary     = (cnt_q == '1) && (rep_q == REP_LAST);
        fifo_pop     = enable_i &&
                       (((state_q == PRIME) && primed) || ((state_q == PLAY) && boundary));
        underrun_set = enable_i && (state_q == PLAY) && boundary && empty_o;
        cnt_d        = cnt_q + 1'b1;
        rep_d        = rep_q + 1'b1;
    end

    // Playback sequencer, period/repeat counters, PWM compare and underrun flag.
    always_ff @(posedge pclk_i) begin
        if (!presetn_i) begin
            state_q      <= IDLE;
            cur_sample_q <= '0;
            cnt_q        <= '0;
            rep_q        <= '0;
            underrun_q   <= 1'b0;
            pwm_q        <= 1'b0;
        end else begin
            // Setting wins over a coincident clear.
            if (underrun_set)        underrun_q <= 1'b1;
            else if (clr_underrun_i) underrun_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    pwm_q <= 1'b0;
                    cnt_q <= '0;
                    rep_q <= '0;
                    if (enable_i) state_q <= PRIME;
                end
                PRIME: begin
                    pwm_q <= 1'b0;
                    if (!enable_i) begin
                        state_q <= IDLE;
                    end else if (primed) begin
                        cur_sample_q <= fifo_head;
                        cnt_q        <= '0;
                        rep_q        <= '0;
                        state_q      <= PLAY;
                    end
                end
                PLAY: begin
                    if (!enable_i) begin
                        // FIFO contents are kept; restart goes through PRIME.
                        state_q <= IDLE;
                        pwm_q   <= 1'b0;
                        cnt_q   <= '0;
                        rep_q   <= '0;
                    end else begin
                        pwm_q <= (cnt_q < cur_sample_q);
                        cnt_q <= cnt_d;
                        if (boundary) begin
                            rep_q        <= '0;
                            cur_sample_q <= empty_o ? SILENCE : fifo_head;
                        end else if (cnt_q == '1) begin
                            rep_q <= rep_d;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aud_sample_pwm.sv
// Self-checking bench for aud_sample_pwm: an elapsed-time reference model
// compared every cycle, plus hand-computed duty/level expectations.
module tb_aud_sample_pwm;

    localparam int SW     = 8;
    localparam int DEPTH  = 16;
    localparam int REPEAT = 8;
    localparam int PRIME  = 4;
    localparam int PERIOD = 1 << SW;
    localparam int SLOT   = PERIOD * REPEAT;

    logic          pclk_i = 1'b0;
    logic          presetn_i = 1'b0;
    logic          enable_i = 1'b0;
    logic [SW-1:0] sample_i = '0;
    logic          sample_valid_i = 1'b0;
    logic          clr_underrun_i = 1'b0;
    logic          sample_ready_o;
    logic [4:0]    level_o;
    logic          empty_o, full_o, underrun_o, busy_o, aud_pwm_o;

    aud_sample_pwm #(
        .SAMPLE_W   (SW),
        .FIFO_DEPTH (DEPTH),
        .PWM_REPEAT (REPEAT),
        .PRIME_LVL  (PRIME)
    ) dut (
        .pclk_i         (pclk_i),
        .presetn_i      (presetn_i),
        .enable_i       (enable_i),
        .sample_i       (sample_i),
        .sample_valid_i (sample_valid_i),
        .sample_ready_o (sample_ready_o),
        .clr_underrun_i (clr_underrun_i),
        .level_o        (level_o),
        .empty_o        (empty_o),
        .full_o         (full_o),
        .underrun_o     (underrun_o),
        .busy_o         (busy_o),
        .aud_pwm_o      (aud_pwm_o)
    );

    always #5 pclk_i = ~pclk_i;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a sample queue, a playback mode and the time elapsed
    // since playback started; duty and pacing follow from plain arithmetic.
    localparam int M_IDLE = 0, M_PRIME = 1, M_PLAY = 2;
    logic [SW-1:0] mq[$];
    int            m_mode = M_IDLE;
    int            m_t = 0;
    int            m_duty = 0;
    bit            m_under = 0;
    bit            m_pwm = 0;
    bit            m_push, m_set_u;
    bit            chk_en = 0;

    always @(posedge pclk_i) begin
        if (!presetn_i) begin
            mq.delete();
            m_mode = M_IDLE; m_t = 0; m_duty = 0; m_under = 0; m_pwm = 0;
        end else begin
            m_push  = sample_valid_i && (mq.size() < DEPTH);
            m_set_u = 0;
            case (m_mode)
                M_IDLE: begin
                    m_pwm = 0;
                    if (enable_i) m_mode = M_PRIME;
                end
                M_PRIME: begin
                    m_pwm = 0;
                    if (!enable_i) m_mode = M_IDLE;
                    else if (mq.size() >= PRIME) begin
                        m_duty = int'(mq.pop_front());
                        m_t = 0;
                        m_mode = M_PLAY;
                    end
                end
                default: begin
                    if (!enable_i) begin
                        m_mode = M_IDLE;
                        m_pwm = 0;
                    end else begin
                        m_pwm = ((m_t % PERIOD) < m_duty);
                        if ((m_t % SLOT) == SLOT - 1) begin
                            if (mq.size() == 0) begin
                                m_duty = PERIOD / 2;
                                m_set_u = 1;
                            end else begin
                                m_duty = int'(mq.pop_front());
                            end
                        end
                        m_t++;
                    end
                end
            endcase
            if (m_push) mq.push_back(sample_i);
            if (m_set_u) m_under = 1;
            else if (clr_underrun_i) m_under = 0;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge pclk_i) begin
        if (chk_en) begin
            check("level", 32'(level_o), 32'(mq.size()));
            check("empty", 32'(empty_o), 32'(mq.size() == 0));
            check("full", 32'(full_o), 32'(mq.size() == DEPTH));
            check("ready", 32'(sample_ready_o), 32'(mq.size() < DEPTH));
            check("underrun", 32'(underrun_o), 32'(m_under));
            check("busy", 32'(busy_o), 32'(m_mode == M_PLAY));
            check("pwm", 32'(aud_pwm_o), 32'(m_pwm));
        end
    end

    // Called at a negedge; holds valid until accepted, returns at the negedge after the push.
    task automatic push_s(input logic [SW-1:0] d);
        int guard = 0;
        sample_valid_i = 1'b1;
        sample_i = d;
        while (!sample_ready_o && guard < 5000) begin
            @(negedge pclk_i);
            guard++;
        end
        if (guard >= 5000) check("push_timeout", 32'(guard), 32'd0);
        @(negedge pclk_i);
        sample_valid_i = 1'b0;
    endtask

    task automatic wait_busy(input string name);
        int guard = 0;
        while (!busy_o && guard < 200) begin
            @(negedge pclk_i);
            guard++;
        end
        if (guard >= 200) check(name, 32'(busy_o), 32'd1);
    endtask

    task automatic count_period(output int hi);
        hi = 0;
        repeat (PERIOD) begin
            @(negedge pclk_i);
            hi += int'(aud_pwm_o);
        end
    endtask

    task automatic pulse_clr();
        repeat (50) @(negedge pclk_i);
        clr_underrun_i = 1'b1;
        @(negedge pclk_i);
        clr_underrun_i = 1'b0;
        @(negedge pclk_i);
        check("underrun_cleared", 32'(underrun_o), 32'd0);
    endtask

    task automatic reset_pulse();
        presetn_i = 1'b0;
        @(negedge pclk_i);
        presetn_i = 1'b1;
    endtask

    int duty_tab[6]  = '{64, 128, 192, 255, 128, 32};
    int lvl_tab[6]   = '{2, 1, 0, 0, 0, 0};
    int under_tab[6] = '{0, 0, 0, 1, 1, 1};

    initial begin
        int hi;
        int rate;

        // Reset state.
        repeat (3) @(negedge pclk_i);
        chk_en = 1;
        check("rst_level", 32'(level_o), 32'd0);
        check("rst_empty", 32'(empty_o), 32'd1);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_ready", 32'(sample_ready_o), 32'd1);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_pwm", 32'(aud_pwm_o), 32'd0);
        presetn_i = 1'b1;
        @(negedge pclk_i);

        // Enabled with nothing queued: must stay primed-but-silent.
        enable_i = 1'b1;
        repeat (10000) @(negedge pclk_i);
        check("prime_busy", 32'(busy_o), 32'd0);
        check("prime_pwm", 32'(aud_pwm_o), 32'd0);
        enable_i = 1'b0;
        @(negedge pclk_i);

        // Four samples, then underrun, refill, and flag clear.
        push_s(8'h40); push_s(8'h80); push_s(8'hC0); push_s(8'hFF);
        check("queued4", 32'(level_o), 32'd4);
        enable_i = 1'b1;
        wait_busy("start_timeout");
        check("first_pop_level", 32'(level_o), 32'd3);
        for (int s = 0; s < 6; s++) begin
            for (int p = 0; p < REPEAT; p++) begin
                if (s == 4 && p == 0) begin
                    fork
                        push_s(8'h20);
                        count_period(hi);
                    join
                end else if (s == 5 && p == 0) begin
                    fork
                        pulse_clr();
                        count_period(hi);
                    join
                end else begin
                    count_period(hi);
                end
                check($sformatf("duty_s%0d_p%0d", s, p), 32'(hi), 32'(duty_tab[s]));
            end
            check($sformatf("slot_level_s%0d", s), 32'(level_o), 32'(lvl_tab[s]));
            check($sformatf("slot_underrun_s%0d", s), 32'(underrun_o), 32'(under_tab[s]));
        end
        enable_i = 1'b0;
        @(negedge pclk_i);

        // Fill to full while disabled; 17th sample held until the first pop.
        reset_pulse();
        for (int i = 0; i < DEPTH; i++) push_s(SW'(i * 16 + 1));
        check("full_flag", 32'(full_o), 32'd1);
        check("full_ready", 32'(sample_ready_o), 32'd0);
        check("full_level", 32'(level_o), 32'd16);
        sample_valid_i = 1'b1;
        sample_i = 8'hAA;
        repeat (5) @(negedge pclk_i);
        check("held_level", 32'(level_o), 32'd16);
        enable_i = 1'b1;
        wait_busy("full_start_timeout");
        check("after_pop_level", 32'(level_o), 32'd15);
        check("after_pop_ready", 32'(sample_ready_o), 32'd1);
        @(negedge pclk_i);
        check("accept_17th", 32'(level_o), 32'd16);
        sample_valid_i = 1'b0;
        enable_i = 1'b0;
        @(negedge pclk_i);

        // Drop enable mid-period, then re-prime.
        reset_pulse();
        push_s(8'hFF); push_s(8'hFF); push_s(8'hFF); push_s(8'hFF);
        enable_i = 1'b1;
        wait_busy("drop_start_timeout");
        repeat (100) @(negedge pclk_i);
        check("pwm_mid_period", 32'(aud_pwm_o), 32'd1);
        enable_i = 1'b0;
        @(negedge pclk_i);
        check("drop_pwm", 32'(aud_pwm_o), 32'd0);
        check("drop_busy", 32'(busy_o), 32'd0);
        check("drop_level", 32'(level_o), 32'd3);
        enable_i = 1'b1;
        repeat (50) @(negedge pclk_i);
        check("reprime_wait", 32'(busy_o), 32'd0);
        push_s(8'h10);
        wait_busy("reprime_timeout");
        check("reprime_level", 32'(level_o), 32'd3);

        // Reset in the middle of playback.
        repeat (300) @(negedge pclk_i);
        reset_pulse();
        check("midrst_level", 32'(level_o), 32'd0);
        check("midrst_pwm", 32'(aud_pwm_o), 32'd0);
        check("midrst_underrun", 32'(underrun_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);

        // Randomized traffic with varying push rates, enable toggles, clears and resets.
        for (int c = 0; c < 6; c++) begin
            rate = int'($urandom_range(1, 4));
            repeat (5000) begin
                @(negedge pclk_i);
                presetn_i      = ($urandom_range(0, 24999) != 0);
                sample_valid_i = ($urandom_range(0, 3999) < rate);
                sample_i       = SW'($urandom);
                clr_underrun_i = ($urandom_range(0, 2999) == 0);
                if ($urandom_range(0, 3999) == 0) enable_i = ~enable_i;
            end
        end
        @(negedge pclk_i);
        presetn_i = 1'b1;
        sample_valid_i = 1'b0;
        clr_underrun_i = 1'b0;
        enable_i = 1'b0;
        repeat (3) @(negedge pclk_i);
        chk_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
